// File: rtl/undo_pkg.sv
// Shared defaults and pointer type for the undo stack.
package undo_pkg;
  localparam int WIDTH_DEFAULT = 16;
  localparam int DEPTH_DEFAULT = 16;
  localparam int UPTR_W        = $clog2(DEPTH_DEFAULT);

  typedef logic [UPTR_W-1:0] uptr_t;
endpackage

// File: rtl/undo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, two asynchronous read ports.
module undo_ram import undo_pkg::*; #(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [PTR_W-1:0] raddr_b,
  output logic [WIDTH-1:0] rdata_b
);
  logic [WIDTH-1:0] mem_r [DEPTH];

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_r[raddr_a];
  assign rdata_b = mem_r[raddr_b];
endmodule

// File: rtl/undo_stack.sv
// Circular undo stack with registered pop, offset peek and sticky overflow/underflow.
// Optional UNDO_STACK_COMMIT_EN adds a commit port that discards all live entries.
module undo_stack import undo_pkg::*; #(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
`ifdef UNDO_STACK_COMMIT_EN
  input  logic             commit,
`endif
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  input  logic [PTR_W-1:0] peek_off,
  output logic [WIDTH-1:0] peek_data,
  output logic             peek_valid,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  logic [PTR_W-1:0] usp_r;
  logic [PTR_W:0]   count_r;
  logic [WIDTH-1:0] pop_data_r;
  logic             pop_valid_r, overflow_r, underflow_r;

  logic [PTR_W-1:0] top_idx_s, peek_idx_s, waddr_s;
  logic [WIDTH-1:0] top_data_s, peek_raw_s;
  logic             do_pop_s, we_s, full_s, commit_s;

`ifdef UNDO_STACK_COMMIT_EN
  assign commit_s = commit;
`else
  assign commit_s = 1'b0;
`endif

  assign top_idx_s  = usp_r - PTR_W'(1);
  assign peek_idx_s = top_idx_s - peek_off;
  assign full_s     = (count_r == (PTR_W+1)'(DEPTH));
  assign do_pop_s   = pop && (count_r != (PTR_W+1)'(0));
  assign peek_valid = ({1'b0, peek_off} < count_r);

  // A successful same-cycle pop turns the push into a top-of-stack replace.
  always_comb begin
    we_s    = push && !reset;
    waddr_s = usp_r;
    if (do_pop_s) begin
      waddr_s = top_idx_s;
    end else begin
      waddr_s = usp_r;
    end
  end

  undo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk     (clk),
    .we      (we_s),
    .waddr   (waddr_s),
    .wdata   (push_data),
    .raddr_a (top_idx_s),
    .rdata_a (top_data_s),
    .raddr_b (peek_idx_s),
    .rdata_b (peek_raw_s)
  );

  // Peek is masked to zero outside the live region.
  always_comb begin
    if (peek_valid) begin
      peek_data = peek_raw_s;
    end else begin
      peek_data = {WIDTH{1'b0}};
    end
  end

  // Pointer, occupancy, pop register and sticky flags; commit overrides count last.
  always_ff @(posedge clk) begin
    if (reset) begin
      usp_r       <= PTR_W'(0);
      count_r     <= (PTR_W+1)'(0);
      pop_data_r  <= {WIDTH{1'b0}};
      pop_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      pop_valid_r <= do_pop_s;
      if (do_pop_s) begin
        pop_data_r <= top_data_s;
      end
      if (pop && !do_pop_s) begin
        underflow_r <= 1'b1;
      end
      if (push && !do_pop_s) begin
        usp_r <= usp_r + PTR_W'(1);
        if (full_s) begin
          overflow_r <= 1'b1;
        end else begin
          count_r <= count_r + (PTR_W+1)'(1);
        end
      end else if (do_pop_s && !push) begin
        usp_r   <= top_idx_s;
        count_r <= count_r - (PTR_W+1)'(1);
      end
      if (commit_s) begin
        count_r <= (PTR_W+1)'(0);
      end
    end
  end

  assign pop_data  = pop_data_r;
  assign pop_valid = pop_valid_r;
  assign count     = count_r;
  assign empty     = (count_r == (PTR_W+1)'(0));
  assign full      = full_s;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
endmodule

// File: doc/undo_stack.md
Name: undo_stack

Overview:
- Parametrised, circular undo buffer for the reversible pipeline.
- Generalises the fixed 16-entry `u` array and its `usp` pointer into a standalone block.
- Provides push, pop with registered output, an offset peek for Und-type operands, occupancy tracking, and overflow reporting.
- Stage 2 instantiates it: push in forward mode, pop on reverse restore.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 16, number of entries; must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH), pointer and offset width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- push  in  1  write push_data at top of stack this cycle.
- push_data  in  WIDTH  value to save.
- pop  in  1  remove top entry this cycle.
- pop_data  out  WIDTH  popped value, registered.
- pop_valid  out  1  pop_data valid; single-cycle pulse.
- peek_off  in  PTR_W  offset below top (0 = top entry).
- peek_data  out  WIDTH  combinational read of entry usp-1-peek_off.
- peek_valid  out  1  peek_off < count.
- count  out  PTR_W+1  live entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky; oldest entry was overwritten.
- underflow  out  1  sticky; pop issued while empty.
- commit  in  1  present only with UNDO_STACK_COMMIT_EN.

Behaviour:
- Reset (synchronous, active-high):
  - usp=0, count=0, pop_data=0, pop_valid=0, overflow=0, underflow=0.
  - Storage contents are not cleared.
- usp indexes the next free slot. All pointer arithmetic is modulo DEPTH (wraps at PTR_W bits).
- Push only:
  - mem[usp]<=push_data, usp<=usp+1.
  - count<=min(count+1,DEPTH).
  - If already full, the oldest entry is silently overwritten and overflow<=1.
- Pop only, count>0:
  - pop_data<=mem[usp-1], pop_valid<=1 next cycle (latency 1).
  - usp<=usp-1, count<=count-1.
- Pop only, count==0:
  - usp and count unchanged, pop_valid<=0, pop_data holds its value, underflow<=1.
- Push and pop in the same cycle, count>0:
  - Pop sees the pre-push top: pop_data<=mem[usp-1], pop_valid<=1.
  - mem[usp-1]<=push_data, i.e. the top is replaced.
  - usp and count unchanged; overflow is not set even when full.
- Push and pop in the same cycle, count==0:
  - Treated as push only.
  - underflow<=1, pop_valid<=0.
- Peek:
  - peek_data=mem[usp-1-peek_off] (wrapping), valid only when peek_valid.
  - If !peek_valid, peek_data=0.
  - Peek reflects state before this cycle's push/pop.
- pop_valid deasserts on any cycle without a successful pop.
- Reset asserted in the same cycle as push/pop: reset wins and nothing is written.
- overflow and underflow clear only on reset.

Optional Feature:
- UNDO_STACK_COMMIT_EN defined:
  - commit port exists. commit=1 sets count<=0 next cycle; usp and storage are unchanged.
  - Committed entries can no longer be popped or peeked, matching the ISA `com` semantics.
  - Priority: commit is applied after the same-cycle push/pop. Push+commit gives count=0.
  - commit does not clear overflow or underflow.
- Undefined: no commit port; count changes only via push/pop.

Decomposition:
- Shared package undo_pkg holds:
  - WIDTH default constant.
  - DEPTH default constant.
  - Pointer typedef `UPTR-equivalent sized from DEPTH.
- One sub-module, undo_ram:
  - DEPTH x WIDTH array, one synchronous write port, two asynchronous read ports (top, peek).
  - The pop register lives in undo_stack.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 -> count=3, peek_off=0 gives 0x3333, peek_off=2 gives 0x1111, peek_off=3 gives peek_valid=0 and peek_data=0.
- Then pop x3 -> pop_data 0x3333, 0x2222, 0x1111 on successive cycles with pop_valid=1, then empty=1. A 4th pop -> pop_valid=0, underflow=1, count=0.
- DEPTH=16: push 0..16 (17 values) -> full=1, count=16, overflow=1; then 16 pops return 16..1, never value 0.
- count=2 (top 0xAAAA), push 0xBBBB with pop in the same cycle -> pop_data=0xAAAA, count=2, peek_off=0 gives 0xBBBB.
- Assert reset mid-stream with count=5 and push high -> next cycle count=0, empty=1, overflow=0, pop_valid=0; a following pop gives underflow=1.
- With UNDO_STACK_COMMIT_EN: push 3 values, commit -> count=0, empty=1; then pop -> underflow=1; push 0x4444 and pop -> returns 0x4444.
